// File: rtl/video_timing_gen.sv
// Raster timing generator: walks a pixel/line grid and emits registered
// vs/hs/de, active-pixel coordinates and a frame-start pulse.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int HS_POL   = 1,
    parameter int VS_POL   = 1,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             vs_out,
    output logic             hs_out,
    output logic             de_out,
    output logic [CNT_W-1:0] x_pos,
    output logic [CNT_W-1:0] y_pos,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             h_wrap;
    logic             de_cur;
    logic             hs_cur;
    logic             vs_cur;
    logic             fs_cur;

    // Half-open range compares: a zero-width region is simply never true,
    // so skipped porches/syncs need no special casing.
    always_comb begin
        de_cur = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        hs_cur = (h_cnt >= HS_START) && (h_cnt < HS_END);
        vs_cur = (v_cnt >= VS_START) && (v_cnt < VS_END);
        fs_cur = (h_cnt == '0) && (v_cnt == '0);
    end

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_cnt + CNT_W'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            h_nxt = '0;
            if (v_cnt == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = v_cnt + CNT_W'(1);
            end
        end
    end

    // Disabling clears the counters so the next enabled edge is frame-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_out      <= 1'b0;
            hs_out      <= ~HS_ON;
            vs_out      <= ~VS_ON;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            de_out      <= 1'b0;
            hs_out      <= ~HS_ON;
            vs_out      <= ~VS_ON;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_start <= 1'b0;
        end else begin
            de_out      <= de_cur;
            hs_out      <= hs_cur ? HS_ON : ~HS_ON;
            vs_out      <= vs_cur ? VS_ON : ~VS_ON;
            x_pos       <= de_cur ? h_cnt : '0;
            y_pos       <= de_cur ? v_cnt : '0;
            frame_start <= fs_cur;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Testbench for video_timing_gen: a small-raster instance of each sync polarity
// is compared every cycle against a frame-position reference model.
module tb_video_timing_gen;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 4;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int CNT_W    = 12;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic             clk;
    logic             rst;
    logic             en;
    logic             vs_p, hs_p, de_p, fs_p;
    logic             vs_n, hs_n, de_n, fs_n;
    logic [CNT_W-1:0] x_p, y_p, x_n, y_n;

    int errors;
    int checks;

    // Reference model: position within the frame, and the outputs it implies.
    int   pos;
    logic m_de, m_hs, m_vs, m_fs;
    int   m_x, m_y;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1), .VS_POL(1), .CNT_W(CNT_W)
    ) dut_p (
        .clk(clk), .rst(rst), .en(en),
        .vs_out(vs_p), .hs_out(hs_p), .de_out(de_p),
        .x_pos(x_p), .y_pos(y_p), .frame_start(fs_p)
    );

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(0), .VS_POL(0), .CNT_W(CNT_W)
    ) dut_n (
        .clk(clk), .rst(rst), .en(en),
        .vs_out(vs_n), .hs_out(hs_n), .de_out(de_n),
        .x_pos(x_n), .y_pos(y_n), .frame_start(fs_n)
    );

    always #5 clk = ~clk;

    task automatic compareValue(input string tag, input logic [CNT_W-1:0] obs,
                                input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic modelIdle();
        pos  = 0;
        m_de = 1'b0;
        m_hs = 1'b0;
        m_vs = 1'b0;
        m_fs = 1'b0;
        m_x  = 0;
        m_y  = 0;
    endtask

    // One clock edge of the reference: emit the pixel at pos, then advance.
    task automatic modelStep(input logic en_v, input logic rst_v);
        int line;
        int pix;
        if (rst_v || !en_v) begin
            modelIdle();
        end else begin
            line = pos / H_TOTAL;
            pix  = pos % H_TOTAL;
            m_de = (pix < H_ACTIVE) && (line < V_ACTIVE);
            m_hs = (pix >= H_ACTIVE + H_FP) && (pix < H_ACTIVE + H_FP + H_SYNC);
            m_vs = (line >= V_ACTIVE + V_FP) && (line < V_ACTIVE + V_FP + V_SYNC);
            m_fs = (pos == 0);
            m_x  = m_de ? pix : 0;
            m_y  = m_de ? line : 0;
            pos  = (pos + 1) % FRAME;
        end
    endtask

    task automatic checkOutput();
        compareValue("de_p", CNT_W'(de_p), CNT_W'(m_de));
        compareValue("hs_p", CNT_W'(hs_p), CNT_W'(m_hs));
        compareValue("vs_p", CNT_W'(vs_p), CNT_W'(m_vs));
        compareValue("fs_p", CNT_W'(fs_p), CNT_W'(m_fs));
        compareValue("x_p", x_p, CNT_W'(m_x));
        compareValue("y_p", y_p, CNT_W'(m_y));
        compareValue("de_n", CNT_W'(de_n), CNT_W'(m_de));
        compareValue("hs_n", CNT_W'(hs_n), CNT_W'(!m_hs));
        compareValue("vs_n", CNT_W'(vs_n), CNT_W'(!m_vs));
        compareValue("fs_n", CNT_W'(fs_n), CNT_W'(m_fs));
        compareValue("x_n", x_n, CNT_W'(m_x));
        compareValue("y_n", y_n, CNT_W'(m_y));
    endtask

    task automatic applyStimulus(input logic en_v, input logic rst_v, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            en  = en_v;
            rst = rst_v;
            @(posedge clk);
            modelStep(en_v, rst_v);
            @(negedge clk);
            checkOutput();
        end
    endtask

    initial begin
        int r;
        errors = 0;
        checks = 0;
        clk    = 1'b0;
        rst    = 1'b1;
        en     = 1'b1;
        modelIdle();

        // Reset state
        applyStimulus(1'b1, 1'b1, 3);

        // First enabled edge emits pixel (0,0) with frame_start
        applyStimulus(1'b1, 1'b0, 1);
        compareValue("first_fs", CNT_W'(fs_p), CNT_W'(1));
        compareValue("first_de", CNT_W'(de_p), CNT_W'(1));

        // Two full frames of line and frame timing
        applyStimulus(1'b1, 1'b0, 2 * FRAME - 1);

        // Pause mid line 2, then resume frame-aligned
        applyStimulus(1'b1, 1'b0, 40);
        applyStimulus(1'b0, 1'b0, 5);
        applyStimulus(1'b1, 1'b0, 1);
        compareValue("resume_fs", CNT_W'(fs_p), CNT_W'(1));
        compareValue("resume_x", x_p, CNT_W'(0));
        compareValue("resume_y", y_p, CNT_W'(0));

        // Run into vsync, then reset asynchronously between edges
        applyStimulus(1'b1, 1'b0, 80);
        compareValue("vs_in_sync", CNT_W'(vs_p), CNT_W'(1));
        #2 rst = 1'b1;
        #1;
        modelIdle();
        compareValue("async_vs_p", CNT_W'(vs_p), CNT_W'(0));
        compareValue("async_vs_n", CNT_W'(vs_n), CNT_W'(1));
        checkOutput();
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b0, 1);
        compareValue("rst_restart_fs", CNT_W'(fs_p), CNT_W'(1));
        applyStimulus(1'b1, 1'b0, FRAME);

        // Randomised enable drops and reset pulses
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                applyStimulus(1'b1, 1'b1, 1 + int'($urandom_range(0, 2)));
            end else if (r < 12) begin
                applyStimulus(1'b0, 1'b0, 1 + int'($urandom_range(0, 4)));
            end else begin
                applyStimulus(1'b1, 1'b0, 1 + int'($urandom_range(0, 30)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator for the HDMI picture pipeline.
- Produces vs/hs/de plus active-pixel coordinates that drive the pixel source (picture ROM address / grey conversion). The same vs/hs/de then feed the sync-alignment delay stage downstream.
- Line order: active, front porch, sync, back porch. Frame order: the same, counted in lines.
- All outputs are registered.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (clocks)
- H_SYNC, 40, hsync width (clocks)
- H_BP, 220, horizontal back porch (clocks)
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines)
- HS_POL, 1, hsync active level (1 = active-high)
- VS_POL, 1, vsync active level
- CNT_W, 12, counter and coordinate width; must satisfy 2^CNT_W > H_TOTAL and 2^CNT_W > V_TOTAL

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- en  input  1  timing run enable
- vs_out  output  1  vertical sync, polarity VS_POL
- hs_out  output  1  horizontal sync, polarity HS_POL
- de_out  output  1  data enable, high during active pixels
- x_pos  output  CNT_W  active pixel column, 0..H_ACTIVE-1
- y_pos  output  CNT_W  active line, 0..V_ACTIVE-1
- frame_start  output  1  single-cycle pulse on the first active pixel of each frame

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Internal counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1).
  - h_cnt wraps from H_TOTAL-1 to 0; v_cnt increments only on that h wrap.
  - v_cnt wraps from V_TOTAL-1 to 0 on the h wrap that occurs when v_cnt = V_TOTAL-1.
- Reset (asynchronous, any time including mid-frame):
  - h_cnt = v_cnt = 0.
  - de_out = 0, frame_start = 0, x_pos = y_pos = 0.
  - hs_out = ~HS_POL, vs_out = ~VS_POL.
- Each rising edge with en=1: outputs are registered from the current counters, then the counters advance. Latency is 1 clock from counter state to outputs.
  - de_out = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_out = HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL.
  - vs_out = VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for the whole line including blanking; otherwise ~VS_POL.
  - x_pos = h_cnt and y_pos = v_cnt when de is true; otherwise both are 0.
  - frame_start = 1 only when h_cnt = 0 and v_cnt = 0.
- en=0:
  - Counters are cleared to 0.
  - de_out = 0, frame_start = 0, x_pos = y_pos = 0, syncs inactive.
  - The first edge with en=1 again emits pixel (0,0) with frame_start = 1. A restart is therefore always frame-aligned.
- en dropped mid-line: outputs go idle on the next edge. No partial-line completion.
- Sync boundaries:
  - With H_FP = 0, hs asserts immediately after the last active pixel.
  - With any porch or sync width = 0, that region is skipped. The comparisons above must handle this with no glitch cycle.
- The counters never exceed TOTAL-1. There is no overflow path.

Test Plan:
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2 (H_TOTAL=15); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); HS_POL=VS_POL=1.
1. Release rst with en=1 -> first edge: de_out=1, x_pos=0, y_pos=0, frame_start=1. de_out stays high 8 cycles with x_pos 0..7, then low 7 cycles.
2. Line timing -> hs_out high exactly cycles 10..12 of each 15-cycle line, counted from x_pos=0. hs_out toggles on every line, including vertical blanking.
3. Frame timing -> de_out active only on lines 0..3. vs_out high on lines 5..6 (cycles 75..104 after frame_start). frame_start repeats every 120 cycles. y_pos steps 0..3.
4. en=0 at cycle 40 (mid line 2) for 5 cycles, then en=1 -> during the pause de/hs/vs are inactive and x_pos = y_pos = 0. The first edge after re-enable gives frame_start=1, x_pos=0, y_pos=0.
5. Assert rst at cycle 80 (inside vsync) -> vs_out drops to 0 asynchronously, without waiting for a clock edge. After release the sequence restarts exactly as in scenario 1.
6. Polarity: rerun scenario 2 with HS_POL=0, VS_POL=0 -> hs/vs idle high and pulse low at the same cycles.
